instruction_fetch_unit: RTL and testbench

Requester side of the instruction-memory interface: holds the per-core program counter, issues word-aligned byte-address read requests to the instruction memory, and buffers returned words in a small in-order queue for the decode stage. It sits between the core's redirect logic (branch/jump/exception) and decode, one instance per core. At most one memory request is outstanding; redirects flush the queue and discard any in-flight response.

---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect input,
// and the decode-facing instruction queue head.
interface instruction_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        DecValid;
    logic        DecReady;
    logic [31:0] DecInstr;
    logic [31:0] DecPC;

    // Fetch unit side
    modport master (
        output ImemReq, ImemAddr, DecValid, DecInstr, DecPC,
        input  ImemReady, ImemRvalid, ImemRdata, Redirect, RedirectPC, DecReady
    );

    // Memory / redirect / decode side
    modport slave (
        input  ImemReq, ImemAddr, DecValid, DecInstr, DecPC,
        output ImemReady, ImemRvalid, ImemRdata, Redirect, RedirectPC, DecReady
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, keeps at most one
// instruction-memory read in flight and queues returned words in order
// for decode. A redirect flushes the queue and drops any in-flight word.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    instruction_fetch_unit_if.master io_bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_DROP} state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic [63:0]    r_mem [QDEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_dec_valid;
    logic [31:0]    r_dec_instr;
    logic [31:0]    r_dec_pc;

    logic [31:0]    w_redir_pc;
    logic           w_req;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [63:0]    w_push_data;
    logic [PW-1:0]  w_rd_ptr_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic [63:0]    w_head_nxt;

    assign w_redir_pc  = {io_bus.RedirectPC[31:2], 2'b00};
    // Request is held low during reset even though state already reads ISSUE
    assign w_req       = i_rst_n && (r_state == ST_ISSUE) && !io_bus.Redirect
                         && (r_count < CW'(QDEPTH));
    assign w_accept    = w_req && io_bus.ImemReady;
    assign w_push      = (r_state == ST_WAIT) && io_bus.ImemRvalid && !io_bus.Redirect;
    assign w_pop       = r_dec_valid && io_bus.DecReady && !io_bus.Redirect;
    assign w_push_data = {r_req_pc, io_bus.ImemRdata};

    assign io_bus.ImemReq  = w_req;
    assign io_bus.ImemAddr = r_pc;
    assign io_bus.DecValid = r_dec_valid;
    assign io_bus.DecInstr = r_dec_instr;
    assign io_bus.DecPC    = r_dec_pc;

    // Next read pointer, occupancy and the entry that becomes the queue head
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
        w_count_nxt  = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
        // A word pushed into the slot that is about to be read bypasses the array
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Fetch FSM: PC, request address latch and outstanding-response tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_ISSUE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    if (io_bus.Redirect) begin
                        r_pc <= w_redir_pc;
                    end else if (w_accept) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io_bus.Redirect) begin
                        r_pc    <= w_redir_pc;
                        r_state <= io_bus.ImemRvalid ? ST_ISSUE : ST_DROP;
                    end else if (io_bus.ImemRvalid) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    if (io_bus.Redirect) begin
                        r_pc <= w_redir_pc;
                    end
                    if (io_bus.ImemRvalid) begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_ISSUE;
            endcase
        end
    end

    // Queue storage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Queue pointers, occupancy and registered decode-facing head
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_dec_valid <= 1'b0;
            r_dec_instr <= '0;
            r_dec_pc    <= '0;
        end else if (io_bus.Redirect) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_dec_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_dec_pc    <= w_head_nxt[63:32];
                r_dec_instr <= w_head_nxt[31:0];
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level
// reference model (PC, outstanding flag, drop flag, SV queue of {pc,word}).
module tb_instruction_fetch_unit;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus2 ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    logic [31:0] m_pc, m_reqpc;
    bit          m_out, m_drop;
    logic [63:0] m_q[$];

    // memory model
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 0;

    // knobs
    int p_rdy, p_dec, p_redir, kmax;

    // wrap-instance bookkeeping
    bit          r2_pend = 0;
    logic [31:0] a2_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_reqpc = 32'h0000_0000;
        m_out  = 0;
        m_drop = 0;
        m_q.delete();
    endtask

    task automatic step(input bit rst);
        bit          exp_req, acc, pop, redir, rv, dr, rdy;
        logic [31:0] rpc, rd;
        @(negedge clk);
        rst_n = rst;
        redir = ($urandom_range(99) < p_redir);
        rpc   = $urandom;
        rv    = mem_busy && (mem_cnt == 1);
        rd    = rv ? (mem_addr >> 2) : $urandom;
        dr    = ($urandom_range(99) < p_dec);
        rdy   = !mem_busy && ($urandom_range(99) < p_rdy);
        bus.Redirect   = redir;
        bus.RedirectPC = rpc;
        bus.DecReady   = dr;
        bus.ImemReady  = rdy;
        bus.ImemRvalid = rv;
        bus.ImemRdata  = rd;
        bus2.Redirect   = 1'b0;
        bus2.RedirectPC = 32'h0;
        bus2.DecReady   = 1'b1;
        bus2.ImemReady  = 1'b1;
        bus2.ImemRvalid = r2_pend;
        bus2.ImemRdata  = 32'h0;
        #1;
        if (!rst_n) model_reset();
        exp_req = rst_n && !redir && !m_out && (m_q.size() < QD);
        check_eq("imem_req", 32'(bus.ImemReq), 32'(exp_req));
        check_eq("imem_addr", bus.ImemAddr, m_pc);
        check_eq("dec_valid", 32'(bus.DecValid), 32'(m_q.size() != 0));
        if (!rst_n) begin
            check_eq("rst_dec_pc", bus.DecPC, 32'h0);
            check_eq("rst_dec_instr", bus.DecInstr, 32'h0);
        end else if (m_q.size() != 0) begin
            check_eq("dec_pc", bus.DecPC, m_q[0][63:32]);
            check_eq("dec_instr", bus.DecInstr, m_q[0][31:0]);
        end
        acc = bus.ImemReq && bus.ImemReady;

        if (rst_n) begin
            pop = (m_q.size() != 0) && dr;
            if (redir) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
                if (m_out) begin
                    if (rv) begin
                        m_out = 0;
                        m_drop = 0;
                    end else begin
                        m_drop = 1;
                    end
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_out && rv) begin
                    if (!m_drop) m_q.push_back({m_reqpc, rd});
                    m_out = 0;
                    m_drop = 0;
                end else if (exp_req && rdy) begin
                    m_reqpc = m_pc;
                    m_pc = m_pc + 32'd4;
                    m_out = 1;
                end
            end
        end

        if (mem_busy) begin
            if (mem_cnt == 1) mem_busy = 0;
            else mem_cnt--;
        end
        if (acc) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(kmax, 1);
            mem_addr = bus.ImemAddr;
        end

        if (rst_n && bus2.ImemReq) a2_q.push_back(bus2.ImemAddr);
        r2_pend = rst_n && bus2.ImemReq;
    endtask

    initial begin
        bus.Redirect = 0; bus.RedirectPC = 0; bus.DecReady = 0;
        bus.ImemReady = 0; bus.ImemRvalid = 0; bus.ImemRdata = 0;
        bus2.Redirect = 0; bus2.RedirectPC = 0; bus2.DecReady = 0;
        bus2.ImemReady = 0; bus2.ImemRvalid = 0; bus2.ImemRdata = 0;
        model_reset();

        // straight-line fetch, k=1
        p_rdy = 100; p_dec = 100; p_redir = 0; kmax = 1;
        repeat (3) step(1'b0);
        repeat (20) step(1'b1);

        // wrap-around of the second instance's PC
        check_eq("wrap_count_ok", 32'(a2_q.size() >= 3), 32'd1);
        if (a2_q.size() >= 3) begin
            check_eq("wrap_addr0", a2_q[0], 32'hFFFF_FFF8);
            check_eq("wrap_addr1", a2_q[1], 32'hFFFF_FFFC);
            check_eq("wrap_addr2", a2_q[2], 32'h0000_0000);
        end

        // decode back-pressure fills the queue, then releases
        p_dec = 0;
        repeat (15) step(1'b1);
        p_dec = 100;
        repeat (10) step(1'b1);

        // random mix with redirects and variable latency
        p_rdy = 70; p_dec = 60; p_redir = 10; kmax = 3;
        repeat (400) step(1'b1);

        // memory stall then resume with k up to 3
        p_redir = 0; p_rdy = 0;
        repeat (5) step(1'b1);
        p_rdy = 100;
        repeat (20) step(1'b1);

        // reset mid-operation, late responses must be ignored
        p_redir = 10; kmax = 3;
        repeat (2) step(1'b0);
        repeat (200) step(1'b1);

        // redirect-heavy traffic with fast memory
        p_redir = 40; p_dec = 90; kmax = 1; p_rdy = 90;
        repeat (200) step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
